uart_tx_monitor: RTL and testbench
==================================

Name: uart_tx_monitor

Overview:
- Receive-side decoder for the SoC's `serial_tx` line; sits directly downstream of the UART pin in the system test harness.
- Oversamples the 8N1 serial stream, reassembles bytes and buffers them in a small FIFO.
- Exposes the bytes over a valid/ready stream and keeps error and line-count status, so a checker or host bridge can consume console output without bit-level timing.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range ≥ 4.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, ≥ 2.
- LINE_CHAR, 8'h0A, byte value counted by line_count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- cpu_reset_n  in  1  asynchronous active-low reset.
- serial_tx  in  1  asynchronous UART line from DUT; idle high.
- out_data  out  8  head-of-FIFO byte.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- frame_err  out  1  sticky: stop bit sampled low.
- overflow  out  1  sticky: byte dropped because FIFO was full.
- line_count  out  16  count of received LINE_CHAR bytes; wraps 16'hFFFF → 0.
- clr_status  in  1  synchronous clear of frame_err, overflow and line_count.

Behaviour:
- Reset (async assert, sync release) values:
  - state IDLE; sync flops 1'b1.
  - out_valid 0, out_data 8'h00, frame_err 0, overflow 0, line_count 0.
  - FIFO pointers 0.
- Input sync: 2-flop synchronizer; `rx_s` = second flop. All decisions use `rx_s`.
- Bit timer: counter 0..CLKS_PER_BIT-1; a "tick" fires when it reaches its target.
- FSM:
  - IDLE: rx_s==0 → START; timer loaded for CLKS_PER_BIT/2 (integer division) cycles.
  - START: at tick, sample rx_s.
    - 1 → IDLE (glitch rejected, nothing pushed, no flag).
    - 0 → DATA; bit index 0; timer = CLKS_PER_BIT.
  - DATA: at each tick, shift rx_s into bit[index], LSB first. After bit 7 → STOP; timer = CLKS_PER_BIT.
  - STOP: at tick, sample rx_s.
    - 1 → byte complete, go to IDLE.
    - 0 → set frame_err, discard byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then IDLE. Prevents a break condition from re-triggering.
- Byte complete, in the same cycle as the stop sample:
  - if byte==LINE_CHAR: line_count += 1. This increments even if the FIFO drops the byte.
  - push to FIFO.
- FIFO:
  - Push accepted if not full, or if full with a pop in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Pop when out_valid & out_ready.
  - out_data is registered head; out_valid=1 the cycle after a push into an empty FIFO.
  - Simultaneous push/pop when empty: no pop (out_valid was 0); push lands.
- Latency: from first serial_tx falling edge, out_valid rises after 2 (sync) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles, ±1 for edge phase.
- clr_status has priority over a same-cycle set or increment: the result is cleared. It does not affect FIFO contents or the FSM.
- Line transitions mid-bit are ignored; only tick samples matter. No majority voting.
- Async reset mid-frame: immediate return to reset values. The partially received byte is lost and the FIFO is emptied.

Test Plan (CLKS_PER_BIT=8, FIFO_DEPTH=4 unless noted):
- Send 0x55 then 0xA3 at exact bit timing, out_ready=1 → out_data 0x55 then 0xA3, each valid 1 cycle; frame_err=0.
- Send "OK\n" (0x4F, 0x4B, 0x0A) → three bytes in order; line_count=1. Pulse clr_status → line_count=0.
- Low glitch of 3 cycles on idle line → no byte, flags 0, FSM back to IDLE before next frame, and a following 0x31 decodes correctly.
- Send 0x7E with stop bit held low for 2 bit times, then idle and send 0x12 → frame_err=1, no 0x7E in FIFO, 0x12 received.
- out_ready=0, send 5 bytes 0x01..0x05 → FIFO holds 0x01..0x04, overflow=1. Then out_ready=1 drains exactly 4 bytes.
- Assert cpu_reset_n=0 during bit 4 of 0x99, release, send 0x66 → only 0x66 emitted; all status 0.

Source files
------------

// File: rtl/uart_tx_monitor.sv
// uart_tx_monitor
//   Decodes an 8N1 UART stream (idle-high line) into bytes. It oversamples
//   the line at CLKS_PER_BIT clocks per bit, buffers good bytes in a small
//   FIFO and presents them on a valid/ready stream. It also keeps sticky
//   error flags and a count of LINE_CHAR bytes.
//
// Ports
//   clk          system clock, rising edge
//   cpu_reset_n  asynchronous active-low reset (released synchronously upstream)
//   serial_tx    asynchronous UART line, idle high
//   out_data     head-of-FIFO byte (registered)
//   out_valid    FIFO non-empty (registered)
//   out_ready    consumer accepts out_data when out_valid & out_ready
//   frame_err    sticky: a stop bit was sampled low
//   overflow     sticky: a completed byte was dropped because the FIFO was full
//   line_count   number of LINE_CHAR bytes received, wraps at 16 bits
//   clr_status   synchronous clear of frame_err, overflow and line_count;
//                it wins over a same-cycle set or increment
module uart_tx_monitor #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [7:0]  LINE_CHAR    = 8'h0A
) (
  input  logic        clk,
  input  logic        cpu_reset_n,
  input  logic        serial_tx,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_err,
  output logic        overflow,
  output logic [15:0] line_count,
  input  logic        clr_status
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);

  // The timer counts down to zero, so a load of N-1 gives a tick N cycles later.
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  // ------------------------------------------------------------------
  // Input synchronizer
  // ------------------------------------------------------------------
  logic [1:0] sync_reg;
  logic       rx_s;

  always_ff @(posedge clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], serial_tx};
    end
  end

  assign rx_s = sync_reg[1];

  // ------------------------------------------------------------------
  // Bit-level receiver FSM
  // ------------------------------------------------------------------
  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          tick;
  logic          byte_done;
  logic          stop_bad;

  assign tick      = (timer_reg == '0);
  assign byte_done = (state_reg == STOP) && tick && rx_s;
  assign stop_bad  = (state_reg == STOP) && tick && !rx_s;

  always_ff @(posedge clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'h00;
    end else begin
      // The timer only runs in the states that sample the line on a tick.
      if ((state_reg == START || state_reg == DATA || state_reg == STOP) && !tick) begin
        timer_reg <= timer_reg - 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            // The first sample lands half a bit in, i.e. mid start bit.
            state_reg <= START;
            timer_reg <= HALF_LOAD;
          end
        end
        START: begin
          if (tick) begin
            if (rx_s) begin
              state_reg <= IDLE;  // short low pulse: not a real start bit
            end else begin
              state_reg   <= DATA;
              bit_idx_reg <= 3'd0;
              timer_reg   <= FULL_LOAD;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg[bit_idx_reg] <= rx_s;
            timer_reg              <= FULL_LOAD;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            state_reg <= rx_s ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must return high before a new frame.
          if (rx_s) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Byte FIFO
  // ------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   count_next;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign full = (count_reg == DEPTH_C);
  assign pop  = out_valid && out_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push = byte_done && (!full || pop);
  assign drop = byte_done && full && !pop;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= shift_reg;
    end
  end

  always_ff @(posedge clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      out_valid  <= (count_next != '0);
      // The registered head comes from the array, except when the byte being
      // written this cycle is itself the new head (FIFO empty after a pop).
      if (push && (wr_ptr_reg == rd_ptr_next)) begin
        out_data <= shift_reg;
      end else if (count_next != '0) begin
        out_data <= mem[rd_ptr_next];
      end
    end
  end

  // ------------------------------------------------------------------
  // Status
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      line_count <= 16'h0000;
    end else if (clr_status) begin
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      line_count <= 16'h0000;
    end else begin
      if (stop_bad) begin
        frame_err <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      // Counted on reception, whether or not the FIFO kept the byte.
      if (byte_done && (shift_reg == LINE_CHAR)) begin
        line_count <= line_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_monitor.sv
// tb_uart_tx_monitor
//   Directed bench for uart_tx_monitor with CLKS_PER_BIT=8 and FIFO_DEPTH=4.
//   Inputs change 1 ns after a rising edge. Outputs are sampled on the falling
//   edge, and every byte accepted on the output stream is logged in received.
module tb_uart_tx_monitor;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic        clk;
  logic        cpu_reset_n;
  logic        serial_tx;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        frame_err;
  logic        overflow;
  logic [15:0] line_count;
  logic        clr_status;

  int checks   = 0;
  int failures = 0;
  int valid_cycles = 0;
  logic [7:0] received[$];
  logic [7:0] expected[$];

  uart_tx_monitor #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .LINE_CHAR   (8'h0A)
  ) dut (
    .clk        (clk),
    .cpu_reset_n(cpu_reset_n),
    .serial_tx  (serial_tx),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .line_count (line_count),
    .clr_status (clr_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) valid_cycles++;
    if (out_valid && out_ready) begin
      received.push_back(out_data);
      $display("rx byte 0x%02h at %0t", out_data, $time);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_bytes(input string tag);
    logic [31:0] got;
    check({tag, "_count"}, received.size(), expected.size());
    for (int i = 0; i < expected.size(); i++) begin
      got = (i < received.size()) ? {24'h0, received[i]} : 32'hDEAD;
      check($sformatf("%s[%0d]", tag, i), got, {24'h0, expected[i]});
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial_tx = frame[i];
      cycles(CPB);
    end
    $display("tx byte 0x%02h", b);
  endtask

  initial begin
    cpu_reset_n = 1'b0;
    serial_tx   = 1'b1;
    out_ready   = 1'b1;
    clr_status  = 1'b0;
    cycles(3);
    cpu_reset_n = 1'b1;
    cycles(2);

    // Reset state
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 8'h00);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    check("rst_line_count", line_count, 0);
    cycles(1);

    // Two bytes at exact timing, each valid for a single cycle
    received.delete(); valid_cycles = 0;
    send_byte(8'h55);
    send_byte(8'hA3);
    cycles(20);
    expected = '{8'h55, 8'hA3};
    check_bytes("t1_bytes");
    check("t1_valid_cycles", valid_cycles, 2);
    check("t1_frame_err", frame_err, 0);

    // "OK\n" and line counting
    received.delete();
    send_byte(8'h4F);
    send_byte(8'h4B);
    send_byte(8'h0A);
    cycles(20);
    expected = '{8'h4F, 8'h4B, 8'h0A};
    check_bytes("t2_bytes");
    check("t2_line_count", line_count, 1);
    clr_status = 1'b1;
    cycles(1);
    clr_status = 1'b0;
    check("t2_line_count_clr", line_count, 0);

    // Three-cycle glitch is rejected
    received.delete();
    serial_tx = 1'b0;
    cycles(3);
    serial_tx = 1'b1;
    cycles(3 * CPB);
    check("t3_glitch_count", received.size(), 0);
    check("t3_glitch_valid", out_valid, 0);
    check("t3_frame_err", frame_err, 0);
    check("t3_overflow", overflow, 0);
    send_byte(8'h31);
    cycles(20);
    expected = '{8'h31};
    check_bytes("t3_bytes");

    // Stop bit held low for two bit times
    received.delete();
    serial_tx = 1'b0;          // start
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      serial_tx = (i >= 1 && i <= 6);   // 0x7E, LSB first
      cycles(CPB);
    end
    serial_tx = 1'b0;          // bad stop, held
    cycles(2 * CPB);
    serial_tx = 1'b1;
    cycles(2 * CPB);
    check("t4_frame_err", frame_err, 1);
    check("t4_no_byte", received.size(), 0);
    send_byte(8'h12);
    cycles(20);
    expected = '{8'h12};
    check_bytes("t4_bytes");
    clr_status = 1'b1;
    cycles(1);
    clr_status = 1'b0;
    check("t4_frame_err_clr", frame_err, 0);

    // Overflow with a stalled consumer
    received.delete();
    out_ready = 1'b0;
    for (int b = 1; b <= 5; b++) send_byte(8'(b));
    cycles(20);
    @(negedge clk);
    check("t5_valid", out_valid, 1);
    check("t5_head", out_data, 8'h01);
    check("t5_overflow", overflow, 1);
    check("t5_none_taken", received.size(), 0);
    cycles(1);
    out_ready = 1'b1;
    cycles(12);
    expected = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_bytes("t5_drain");
    check("t5_empty", out_valid, 0);

    // Reset in the middle of 0x99 (during bit 4)
    received.delete();
    serial_tx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      serial_tx = (i == 0 || i == 3);   // bits 0..3 of 0x99
      cycles(CPB);
    end
    serial_tx = 1'b1;                   // bit 4
    cycles(CPB / 2);
    cpu_reset_n = 1'b0;
    cycles(3);
    check("t6_rst_overflow", overflow, 0);
    check("t6_rst_valid", out_valid, 0);
    cpu_reset_n = 1'b1;
    cycles(2 * CPB);
    send_byte(8'h66);
    cycles(20);
    expected = '{8'h66};
    check_bytes("t6_bytes");
    check("t6_frame_err", frame_err, 0);
    check("t6_overflow", overflow, 0);
    check("t6_line_count", line_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
